// File: rtl/result_drain.sv
// result_drain: captures NUM_ROWS MAC results on calc_done and streams them
// out one beat per valid/ready handshake, reporting a checksum of the drain.
module result_drain #(
    parameter int DATA_WIDTH = 24,
    parameter int NUM_ROWS   = 8,
    parameter int SUM_WIDTH  = DATA_WIDTH + $clog2(NUM_ROWS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           calc_done,
    input  logic [NUM_ROWS*DATA_WIDTH-1:0] couts,
    input  logic                           out_ready,
    output logic                           out_valid,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [$clog2(NUM_ROWS)-1:0]    out_idx,
    output logic                           busy,
    output logic                           drain_done,
    output logic [SUM_WIDTH-1:0]           checksum,
    output logic                           drop_err
);

    localparam int IDX_W = $clog2(NUM_ROWS);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        FINISH
    } state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_shadow [NUM_ROWS];
    logic [IDX_W-1:0]      r_cnt;
    logic [SUM_WIDTH-1:0]  r_sum;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_busy;
    logic                  r_drain_done;
    logic [SUM_WIDTH-1:0]  r_checksum;
    logic                  r_drop_err;

    logic                  w_xfer;
    logic                  w_last;
    logic [IDX_W-1:0]      w_cnt_nxt;
    logic [SUM_WIDTH-1:0]  w_sum_nxt;

    // Handshake decode and next-beat arithmetic
    always_comb begin
        w_xfer    = r_out_valid && out_ready;
        w_last    = (r_cnt == IDX_W'(NUM_ROWS - 1));
        w_cnt_nxt = r_cnt + 1'b1;
        w_sum_nxt = r_sum + SUM_WIDTH'(r_out_data);
    end

    // Drain FSM: capture, stream beats, then report checksum for one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_sum        <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_busy       <= 1'b0;
            r_drain_done <= 1'b0;
            r_checksum   <= '0;
            r_drop_err   <= 1'b0;
            for (int unsigned i = 0; i < NUM_ROWS; i++) begin
                r_shadow[i] <= '0;
            end
        end else begin
            // Any capture request outside IDLE (including the FINISH exit cycle) is lost
            if (calc_done && (r_state != IDLE)) begin
                r_drop_err <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (calc_done) begin
                        for (int unsigned i = 0; i < NUM_ROWS; i++) begin
                            r_shadow[i] <= couts[i*DATA_WIDTH +: DATA_WIDTH];
                        end
                        r_cnt       <= '0;
                        r_sum       <= '0;
                        // Row 0 is loaded straight from couts so the first beat
                        // is valid in the cycle right after the capture edge.
                        r_out_data  <= couts[DATA_WIDTH-1:0];
                        r_out_valid <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= SEND;
                    end
                end

                SEND: begin
                    if (w_xfer) begin
                        r_sum <= w_sum_nxt;
                        if (w_last) begin
                            r_out_valid  <= 1'b0;
                            r_checksum   <= w_sum_nxt;
                            r_drain_done <= 1'b1;
                            r_state      <= FINISH;
                        end else begin
                            r_cnt      <= w_cnt_nxt;
                            r_out_data <= r_shadow[w_cnt_nxt];
                        end
                    end
                end

                FINISH: begin
                    r_drain_done <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= IDLE;
                end

                default: begin
                    r_out_valid  <= 1'b0;
                    r_drain_done <= 1'b0;
                    r_busy       <= 1'b0;
                    r_state      <= IDLE;
                end
            endcase
        end
    end

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_idx    = r_cnt;
    assign busy       = r_busy;
    assign drain_done = r_drain_done;
    assign checksum   = r_checksum;
    assign drop_err   = r_drop_err;

endmodule

// File: tb/tb_result_drain.sv
// Testbench for result_drain: directed drains checked by a beat/checksum scoreboard.
module tb_result_drain;

    localparam int DW = 24;
    localparam int NR = 8;
    localparam int IW = 3;
    localparam int SW = 27;

    logic              clk = 1'b0;
    logic              rst;
    logic              calc_done;
    logic [NR*DW-1:0]  couts;
    logic              out_ready;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic [IW-1:0]     out_idx;
    logic              busy;
    logic              drain_done;
    logic [SW-1:0]     checksum;
    logic              drop_err;

    result_drain #(
        .DATA_WIDTH(DW),
        .NUM_ROWS  (NR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .calc_done (calc_done),
        .couts     (couts),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .busy      (busy),
        .drain_done(drain_done),
        .checksum  (checksum),
        .drop_err  (drop_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [IW+DW-1:0] beat_q [$];
    logic [SW-1:0]    sum_q  [$];

    logic          p_stall = 1'b0;
    logic          p_rst   = 1'b1;
    logic [DW-1:0] p_data  = '0;
    logic [IW-1:0] p_idx   = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expected beats/checksums whenever the DUT presents them
    always @(negedge clk) begin
        logic [IW+DW-1:0] exp_beat;
        if (p_stall && !p_rst) begin
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_data", 64'(out_data), 64'(p_data));
            check("hold_idx", 64'(out_idx), 64'(p_idx));
        end
        if (out_valid && out_ready) begin
            checks++;
            if (beat_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: got idx %0d data 0x%0h, expected none", out_idx, out_data);
            end else begin
                exp_beat = beat_q.pop_front();
                check("beat_idx", 64'(out_idx), 64'(exp_beat[IW+DW-1:DW]));
                check("beat_data", 64'(out_data), 64'(exp_beat[DW-1:0]));
            end
        end
        if (drain_done) begin
            checks++;
            if (sum_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_drain_done: got checksum 0x%0h, expected no drain_done", checksum);
            end else begin
                check("checksum", 64'(checksum), 64'(sum_q.pop_front()));
            end
        end
        p_stall = out_valid && !out_ready;
        p_rst   = rst;
        p_data  = out_data;
        p_idx   = out_idx;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NR*DW-1:0] mk(input int base, input int step);
        logic [NR*DW-1:0] r;
        for (int i = 0; i < NR; i++) begin
            r[i*DW +: DW] = DW'(base + step * i);
        end
        return r;
    endfunction

    task automatic push_beats(input logic [NR*DW-1:0] rows, input int n);
        for (int i = 0; i < n; i++) begin
            beat_q.push_back({IW'(i), rows[i*DW +: DW]});
        end
    endtask

    // Issue a one-cycle calc_done; returns 1 time unit into the following cycle
    task automatic pulse(input logic [NR*DW-1:0] rows);
        couts     = rows;
        calc_done = 1'b1;
        tick();
        calc_done = 1'b0;
    endtask

    // Run until drain_done is visible (returns inside the FINISH cycle)
    task automatic run_to_done(input string name);
        for (int k = 0; k < 100; k++) begin
            if (drain_done) break;
            tick();
        end
        check(name, 64'(drain_done), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        calc_done = 1'b0;
        out_ready = 1'b0;
        couts     = '0;
        tick();
        tick();
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", 64'(out_data), 64'd0);
        check("rst_idx", 64'(out_idx), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(drain_done), 64'd0);
        check("rst_checksum", 64'(checksum), 64'd0);
        check("rst_drop", 64'(drop_err), 64'd0);
        rst       = 1'b0;
        out_ready = 1'b1;
        repeat (3) tick();

        // Basic drain: rows 1..8, checksum 36
        push_beats(mk(1, 1), NR);
        sum_q.push_back(SW'(36));
        pulse(mk(1, 1));
        check("basic_first_valid", 64'(out_valid), 64'd1);
        check("basic_first_idx", 64'(out_idx), 64'd0);
        check("basic_busy", 64'(busy), 64'd1);
        run_to_done("basic_done");
        check("basic_finish_valid", 64'(out_valid), 64'd0);
        tick();
        check("basic_busy_low", 64'(busy), 64'd0);
        check("basic_done_pulse", 64'(drain_done), 64'd0);
        check("basic_checksum_hold", 64'(checksum), 64'h24);
        repeat (2) tick();

        // Backpressure: rows 0x100*i, ready pattern 1,0,0 repeating
        push_beats(mk(0, 'h100), NR);
        sum_q.push_back(SW'('h1C00));
        pulse(mk(0, 'h100));
        couts = mk('h5A5A, 7);
        for (int k = 0; k < 100; k++) begin
            if (drain_done) break;
            out_ready = (k % 3 == 0);
            tick();
        end
        check("bp_done", 64'(drain_done), 64'd1);
        out_ready = 1'b1;
        repeat (2) tick();

        // Saturation: all rows max, no wrap
        push_beats(mk('hFFFFFF, 0), NR);
        sum_q.push_back(SW'('h7FFFFF8));
        pulse(mk('hFFFFFF, 0));
        run_to_done("sat_done");
        repeat (2) tick();

        // Dropped capture mid-drain and at FINISH exit
        push_beats(mk(5, 3), NR);
        sum_q.push_back(SW'(124));
        pulse(mk(5, 3));
        for (int k = 0; k < 20; k++) begin
            if (out_valid && out_idx == IW'(3)) break;
            tick();
        end
        check("drop_at_beat3", 64'(out_idx), 64'd3);
        pulse(mk('h777, 1));
        check("drop_flag", 64'(drop_err), 64'd1);
        run_to_done("drop_done");
        pulse(mk('h333, 2));
        check("finish_drop_no_valid", 64'(out_valid), 64'd0);
        check("finish_drop_busy", 64'(busy), 64'd0);
        tick();
        push_beats(mk(2, 2), NR);
        sum_q.push_back(SW'(72));
        pulse(mk(2, 2));
        check("after_drop_valid", 64'(out_valid), 64'd1);
        check("after_drop_idx", 64'(out_idx), 64'd0);
        run_to_done("after_drop_done");
        tick();
        check("drop_sticky", 64'(drop_err), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("drop_cleared", 64'(drop_err), 64'd0);
        tick();

        // Mid-drain reset after beat 4
        push_beats(mk(10, 10), 5);
        pulse(mk(10, 10));
        for (int k = 0; k < 20; k++) begin
            if (out_valid && out_idx == IW'(4)) break;
            tick();
        end
        check("mr_at_beat4", 64'(out_idx), 64'd4);
        tick();
        rst       = 1'b1;
        out_ready = 1'b0;
        tick();
        rst       = 1'b0;
        out_ready = 1'b1;
        check("mr_valid", 64'(out_valid), 64'd0);
        check("mr_checksum", 64'(checksum), 64'd0);
        check("mr_busy", 64'(busy), 64'd0);
        repeat (3) tick();
        check("mr_flush", 64'(beat_q.size()), 64'd0);
        push_beats(mk(3, 1), NR);
        sum_q.push_back(SW'(52));
        pulse(mk(3, 1));
        check("mr_restart_valid", 64'(out_valid), 64'd1);
        check("mr_restart_idx", 64'(out_idx), 64'd0);
        run_to_done("mr_done");

        // Back-to-back: capture in first IDLE cycle after FINISH
        tick();
        push_beats(mk(20, 1), NR);
        sum_q.push_back(SW'(188));
        pulse(mk(20, 1));
        check("b2b_valid", 64'(out_valid), 64'd1);
        check("b2b_idx", 64'(out_idx), 64'd0);
        check("b2b_drop", 64'(drop_err), 64'd0);
        run_to_done("b2b_done");
        repeat (3) tick();
        check("b2b_drop_end", 64'(drop_err), 64'd0);

        check("beat_q_empty", 64'(beat_q.size()), 64'd0);
        check("sum_q_empty", 64'(sum_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/result_drain.md
RESULT_DRAIN -- requirements
Module: result_drain

Interface
REQ-001 Parameter DATA_WIDTH, default 24, width of one MAC result.
REQ-002 Parameter NUM_ROWS, default 8, number of MAC results per capture (power of two, >=2).
REQ-003 Parameter SUM_WIDTH, default DATA_WIDTH+$clog2(NUM_ROWS), checksum width.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst  input  1  reset: synchronous, active-high.
REQ-006 calc_done  input  1  one-cycle pulse from the MAC array: results are final.
REQ-007 couts  input  NUM_ROWS*DATA_WIDTH  packed MAC results, row i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 out_ready  input  1  downstream sink can accept a beat.
REQ-009 out_valid  output  1  out_data/out_idx hold a valid beat.
REQ-010 out_data  output  DATA_WIDTH  current result beat.
REQ-011 out_idx  output  $clog2(NUM_ROWS)  row index of current beat.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 drain_done  output  1  one-cycle pulse after the last beat is accepted.
REQ-014 checksum  output  SUM_WIDTH  sum of all beats of the last completed drain.
REQ-015 drop_err  output  1  sticky: a calc_done arrived while busy.

Function
REQ-016 States IDLE, SEND, FINISH; reset state IDLE.
REQ-017 IDLE: when calc_done=1, all NUM_ROWS results are captured into internal shadow registers on that edge, the row counter and the running sum are cleared, and the state goes to SEND.
REQ-018 Latency: a calc_done sampled at edge N gives out_valid=1 with out_idx=0 after edge N, i.e. in cycle N+1.
REQ-019 SEND: out_valid=1, out_data=shadow[row counter], out_idx=row counter.
REQ-020 A beat transfers on an edge where out_valid=1 and out_ready=1. On transfer the row counter increments and out_data is added to the running sum.
REQ-021 While out_valid=1 and out_ready=0, out_data and out_idx hold stable. out_valid does not drop until the beat is transferred.
REQ-022 Once out_valid is high, it does not depend combinationally on out_ready.
REQ-023 When the beat with out_idx=NUM_ROWS-1 transfers, the state goes to FINISH and out_valid=0 in the next cycle.
REQ-024 FINISH lasts exactly one cycle. drain_done=1 during it, checksum holds the final sum during it, and the state then goes to IDLE.
REQ-025 checksum updates only on entry to FINISH and holds until the next FINISH. The running sum never alters it mid-drain.
REQ-026 Checksum arithmetic is unsigned, SUM_WIDTH bits, with no overflow possible.
REQ-027 Changes on couts after capture do not affect the beats being sent.
REQ-028 calc_done in SEND or FINISH is ignored (no recapture, counter unaffected) and sets drop_err=1. drop_err clears only on rst.
REQ-029 calc_done in the same cycle as the FINISH exit is also a drop. It is not captured.
REQ-030 Back-to-back operation: a calc_done in the first IDLE cycle after FINISH is accepted normally.
REQ-031 busy is registered and equals (state != IDLE).

Reset
REQ-032 While rst=1 on an edge, the following apply:
- state=IDLE
- out_valid=0, out_data=0, out_idx=0
- busy=0, drain_done=0
- checksum=0, drop_err=0
- shadow registers, row counter and running sum cleared
REQ-033 rst takes priority over calc_done and out_ready in the same cycle.
REQ-034 rst asserted mid-drain aborts the drain: no drain_done, checksum=0, and the next calc_done starts a fresh drain at out_idx=0.

Verification
REQ-035 Basic drain:
- Stimulus: couts rows = 1..8, out_ready held 1, calc_done pulse at cycle 10.
- Response: out_valid in cycles 11-18 with idx 0..7 and data 1..8; drain_done in cycle 19; checksum=36; busy low in cycle 20.
REQ-036 Backpressure:
- Stimulus: rows = 0x100*i, out_ready toggles 1,0,0,1,...
- Response: each beat held stable across the stalled cycles; all 8 beats delivered in order; checksum=0x1C00.
REQ-037 Saturation:
- Stimulus: all rows = 0xFFFFFF.
- Response: checksum=0x7FFFFF8 (27 bits), no wrap.
REQ-038 Dropped capture:
- Stimulus: second calc_done at beat 3 with different couts.
- Response: beats continue from the first capture; drop_err=1 and stays 1 after the drain; a subsequent calc_done in IDLE is accepted.
REQ-039 Mid-drain reset:
- Stimulus: rst for 1 cycle after beat 4, then calc_done.
- Response: out_valid=0, checksum=0, no drain_done after reset; the new drain starts at out_idx=0.
REQ-040 Back-to-back:
- Stimulus: calc_done in the first IDLE cycle after drain_done.
- Response: captured; out_valid with idx 0 in the next cycle; drop_err stays 0.
